// File: rtl/l2_port_arbiter.sv
// Shares the single L2 slave port between the JTAG access bridge (port 0) and the
// on-chip test-pattern engine (port 1); responses are routed back in issue order.
module l2_port_arbiter #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [1:0]                  m_req_i,
  input  logic [1:0]                  m_we_i,
  input  logic [2*ADDR_WIDTH-1:0]     m_addr_i,
  input  logic [2*(DATA_WIDTH/8)-1:0] m_be_i,
  input  logic [2*DATA_WIDTH-1:0]     m_wdata_i,
  output logic [1:0]                  m_gnt_o,
  output logic [1:0]                  m_rvalid_o,
  output logic [DATA_WIDTH-1:0]       m_rdata_o,
  output logic                        mem_req_o,
  output logic                        mem_we_o,
  output logic [ADDR_WIDTH-1:0]       mem_addr_o,
  output logic [DATA_WIDTH/8-1:0]     mem_be_o,
  output logic [DATA_WIDTH-1:0]       mem_wdata_o,
  input  logic                        mem_gnt_i,
  input  logic                        mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]       mem_rdata_i,
  output logic                        err_o
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

  logic                       prio_r;
  logic [CNT_W-1:0]           cnt_r;
  logic [PTR_W-1:0]           wr_ptr_r;
  logic [PTR_W-1:0]           rd_ptr_r;
  logic [MAX_OUTSTANDING-1:0] owner_r;
  logic                       err_r;

  logic winner_s;
  logic full_s;
  logic empty_s;
  logic accept_s;
  logic pop_s;
  logic head_s;

  // Full/empty come from registered occupancy only, so mem_rvalid_i never reaches mem_req_o.
  assign full_s  = (cnt_r == CNT_W'(MAX_OUTSTANDING));
  assign empty_s = (cnt_r == CNT_W'(0));

  // Winner selection: a lone requester wins, contention is settled by prio_r.
  always_comb begin
    winner_s = prio_r;
    case (m_req_i)
      2'b01:   winner_s = 1'b0;
      2'b10:   winner_s = 1'b1;
      2'b11:   winner_s = prio_r;
      default: winner_s = prio_r;
    endcase
  end

  assign mem_req_o = (|m_req_i) & ~full_s;
  assign accept_s  = mem_req_o & mem_gnt_i;
  assign pop_s     = mem_rvalid_i & ~empty_s;
  assign head_s    = owner_r[rd_ptr_r];

  // Address-phase mux and per-port grant.
  always_comb begin
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    m_gnt_o     = 2'b00;
    if (winner_s) begin
      mem_we_o    = m_we_i[1];
      mem_addr_o  = m_addr_i[ADDR_WIDTH +: ADDR_WIDTH];
      mem_be_o    = m_be_i[BE_W +: BE_W];
      mem_wdata_o = m_wdata_i[DATA_WIDTH +: DATA_WIDTH];
      m_gnt_o     = {accept_s, 1'b0};
    end else begin
      mem_we_o    = m_we_i[0];
      mem_addr_o  = m_addr_i[0 +: ADDR_WIDTH];
      mem_be_o    = m_be_i[0 +: BE_W];
      mem_wdata_o = m_wdata_i[0 +: DATA_WIDTH];
      m_gnt_o     = {1'b0, accept_s};
    end
  end

  // Response routing to the port recorded at the FIFO head.
  always_comb begin
    m_rvalid_o = 2'b00;
    if (head_s) begin
      m_rvalid_o = {pop_s, 1'b0};
    end else begin
      m_rvalid_o = {1'b0, pop_s};
    end
  end

  assign m_rdata_o = mem_rdata_i;
  assign err_o     = err_r;

  // Round-robin priority flips away from each accepted winner.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prio_r <= 1'b0;
    end else if (accept_s) begin
      prio_r <= ~winner_s;
    end else begin
      prio_r <= prio_r;
    end
  end

  // Owner FIFO storage and pointers; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      owner_r  <= '0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (accept_s) begin
        owner_r[wr_ptr_r] <= winner_s;
        wr_ptr_r          <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
    end
  end

  // Occupancy count; a simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_r <= '0;
    end else begin
      case ({accept_s, pop_s})
        2'b10:   cnt_r <= cnt_r + CNT_W'(1);
        2'b01:   cnt_r <= cnt_r - CNT_W'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // Sticky error on a response with nothing outstanding.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_r <= 1'b0;
    end else if (mem_rvalid_i && empty_s) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Scoreboard bench for l2_port_arbiter: a behavioural L2 model answers accepted
// transfers; expected responses are queued at grant time and compared on m_rvalid_o.
module tb_l2_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [1:0]  m_req_i;
  logic [1:0]  m_we_i;
  logic [63:0] m_addr_i;
  logic [7:0]  m_be_i;
  logic [63:0] m_wdata_i;
  logic [1:0]  m_gnt_o;
  logic [1:0]  m_rvalid_o;
  logic [31:0] m_rdata_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i  = 32'h0;
  logic        err_o;

  logic        p_we   [2];
  logic [31:0] p_addr [2];
  logic [31:0] p_wd   [2];

  assign m_we_i    = {p_we[1], p_we[0]};
  assign m_addr_i  = {p_addr[1], p_addr[0]};
  assign m_wdata_i = {p_wd[1], p_wd[0]};
  assign m_be_i    = 8'hFF;

  l2_port_arbiter dut (
    .clk_i(clk), .rst_i(rst_i),
    .m_req_i(m_req_i), .m_we_i(m_we_i), .m_addr_i(m_addr_i), .m_be_i(m_be_i),
    .m_wdata_i(m_wdata_i), .m_gnt_o(m_gnt_o), .m_rvalid_o(m_rvalid_o), .m_rdata_o(m_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o),
    .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] data;
  } sb_t;
  sb_t sb[$];

  logic [31:0] exp_mem [logic [31:0]];
  logic [31:0] l2_mem  [logic [31:0]];
  logic [31:0] l2_q[$];
  logic        l2_hold  = 1'b0;
  logic        l2_pulse = 1'b0;
  logic        l2_spur  = 1'b0;
  logic        l2_flush = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks the grant at mid-cycle and queues the expected response of a granted port.
  task automatic expect_gnt(input string tag, input logic [1:0] exp);
    sb_t e;
    @(negedge clk);
    check_eq(tag, 32'(m_gnt_o), 32'(exp));
    for (int p = 0; p < 2; p++) begin
      if (exp[p]) begin
        e.port = p[0];
        e.we   = p_we[p];
        if (p_we[p]) begin
          exp_mem[p_addr[p]] = p_wd[p];
          e.data = 32'h0;
        end else begin
          e.data = exp_mem.exists(p_addr[p]) ? exp_mem[p_addr[p]] : 32'h0;
        end
        sb.push_back(e);
      end
    end
    tick();
  endtask

  // Behavioural L2: in-order, one cycle minimum latency, with hold/pulse/spurious/flush controls.
  always begin
    logic        acc, served, we;
    logic [31:0] a, wd, rd;
    logic [3:0]  be;
    @(negedge clk);
    acc    = mem_req_o & mem_gnt_i;
    served = mem_rvalid_i;
    we = mem_we_o; a = mem_addr_o; wd = mem_wdata_o; be = mem_be_o;
    @(posedge clk);
    #2;
    if (served && l2_q.size() > 0) void'(l2_q.pop_front());
    if (acc) begin
      rd = l2_mem.exists(a) ? l2_mem[a] : 32'h0;
      if (we) begin
        for (int b = 0; b < 4; b++) if (be[b]) rd[b*8 +: 8] = wd[b*8 +: 8];
        l2_mem[a] = rd;
        l2_q.push_back(32'h0);
      end else begin
        l2_q.push_back(rd);
      end
    end
    if (l2_flush) begin
      l2_q.delete();
      l2_flush = 1'b0;
    end
    if (l2_spur) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'hDEADBEEF;
      l2_spur      = 1'b0;
    end else if (l2_q.size() > 0 && (!l2_hold || l2_pulse)) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = l2_q[0];
      l2_pulse     = 1'b0;
    end else begin
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = 32'h0;
    end
  end

  // Response monitor: every m_rvalid_o pulse must match the oldest expected response.
  always @(negedge clk) begin
    sb_t e;
    if (!rst_i && m_rvalid_o != 2'b00) begin
      if (sb.size() == 0) begin
        check_eq("rv_unexpected", 32'(m_rvalid_o), 32'h0);
      end else begin
        e = sb.pop_front();
        check_eq("rv_port", 32'(m_rvalid_o), e.port ? 32'h2 : 32'h1);
        if (!e.we) check_eq("rv_rdata", m_rdata_o, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int w;
    rst_i = 1'b1; m_req_i = 2'b00; mem_gnt_i = 1'b1;
    for (int p = 0; p < 2; p++) begin p_we[p] = 1'b0; p_addr[p] = 32'h0; p_wd[p] = 32'h0; end
    repeat (3) tick();
    @(negedge clk);
    check_eq("rst_gnt", 32'(m_gnt_o), 32'h0);
    check_eq("rst_rvalid", 32'(m_rvalid_o), 32'h0);
    check_eq("rst_memreq", 32'(mem_req_o), 32'h0);
    check_eq("rst_err", 32'(err_o), 32'h0);
    tick();
    rst_i = 1'b0;

    // Contention: both ports write continuously, grants must alternate from port 0.
    p_we[0] = 1'b1; p_addr[0] = 32'h100; p_wd[0] = 32'h1000;
    p_we[1] = 1'b1; p_addr[1] = 32'h200; p_wd[1] = 32'h2000;
    m_req_i = 2'b11;
    for (int i = 0; i < 6; i++) begin
      w = i % 2;
      expect_gnt($sformatf("cont_g%0d", i), (w == 1) ? 2'b10 : 2'b01);
      p_addr[w] = p_addr[w] + 32'h4;
      p_wd[w]   = p_wd[w] + 32'h1;
    end
    m_req_i = 2'b00;
    repeat (4) tick();

    // Port 0 write then read back with one-cycle L2.
    p_we[0] = 1'b1; p_addr[0] = 32'h0; p_wd[0] = 32'hABBAABBA;
    m_req_i = 2'b01;
    expect_gnt("p0_wr_gnt", 2'b01);
    m_req_i = 2'b00;
    @(negedge clk);
    check_eq("p0_wr_rv", 32'(m_rvalid_o), 32'h1);
    tick();
    p_we[0] = 1'b0;
    m_req_i = 2'b01;
    expect_gnt("p0_rd_gnt", 2'b01);
    m_req_i = 2'b00;
    @(negedge clk);
    check_eq("p0_rd_rv", 32'(m_rvalid_o), 32'h1);
    check_eq("p0_rd_data", m_rdata_o, 32'hABBAABBA);
    tick();
    repeat (2) tick();

    // Outstanding limit: L2 withholds responses, port 1 issues reads.
    l2_hold = 1'b1;
    p_we[1] = 1'b0; p_addr[1] = 32'h200;
    m_req_i = 2'b10;
    for (int i = 0; i < 4; i++) begin
      expect_gnt($sformatf("lim_g%0d", i), 2'b10);
      p_addr[1] = p_addr[1] + 32'h4;
    end
    @(negedge clk);
    check_eq("lim_full_req", 32'(mem_req_o), 32'h0);
    check_eq("lim_full_gnt", 32'(m_gnt_o), 32'h0);
    tick();
    l2_pulse = 1'b1;
    @(negedge clk);
    check_eq("popfull_gnt", 32'(m_gnt_o), 32'h0);
    check_eq("popfull_req", 32'(mem_req_o), 32'h0);
    check_eq("popfull_rv", 32'(m_rvalid_o), 32'h2);
    tick();
    expect_gnt("lim_g4", 2'b10);
    p_addr[1] = p_addr[1] + 32'h4;
    @(negedge clk);
    check_eq("lim_cnt4_req", 32'(mem_req_o), 32'h0);
    check_eq("lim_cnt4_gnt", 32'(m_gnt_o), 32'h0);
    tick();
    l2_hold = 1'b0;
    @(negedge clk);
    check_eq("lim_wait_gnt", 32'(m_gnt_o), 32'h0);
    tick();
    expect_gnt("lim_g5", 2'b10);
    m_req_i = 2'b00;
    repeat (8) tick();
    check_eq("lim_drained", 32'(sb.size()), 32'h0);

    // Spurious response with nothing outstanding.
    l2_spur = 1'b1;
    @(negedge clk);
    check_eq("spur_rv", 32'(m_rvalid_o), 32'h0);
    check_eq("spur_err_pre", 32'(err_o), 32'h0);
    tick();
    @(negedge clk);
    check_eq("spur_err", 32'(err_o), 32'h1);
    tick();
    repeat (3) tick();
    check_eq("spur_err_sticky", 32'(err_o), 32'h1);

    // Reset with three transfers outstanding, then contended requests.
    l2_hold = 1'b1;
    p_we[0] = 1'b1; p_addr[0] = 32'h300; p_wd[0] = 32'h3000;
    m_req_i = 2'b01;
    for (int i = 0; i < 3; i++) begin
      expect_gnt($sformatf("rb_pre_g%0d", i), 2'b01);
      p_addr[0] = p_addr[0] + 32'h4;
      p_wd[0]   = p_wd[0] + 32'h1;
    end
    m_req_i = 2'b00;
    rst_i = 1'b1;
    l2_flush = 1'b1;
    tick();
    rst_i = 1'b0;
    sb.delete();
    @(negedge clk);
    check_eq("rb_err", 32'(err_o), 32'h0);
    check_eq("rb_req", 32'(mem_req_o), 32'h0);
    tick();
    p_we[0] = 1'b0; p_addr[0] = 32'h300;
    p_we[1] = 1'b0; p_addr[1] = 32'h0;
    m_req_i = 2'b11;
    for (int i = 0; i < 4; i++) begin
      w = i % 2;
      expect_gnt($sformatf("rb_c%0d", i), (w == 1) ? 2'b10 : 2'b01);
      p_addr[w] = p_addr[w] + 32'h4;
    end
    @(negedge clk);
    check_eq("rb_full_req", 32'(mem_req_o), 32'h0);
    tick();
    m_req_i = 2'b00;
    l2_hold = 1'b0;
    repeat (8) tick();
    check_eq("rb_drained", 32'(sb.size()), 32'h0);
    check_eq("final_err", 32'(err_o), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/l2_port_arbiter.md
# l2_port_arbiter

- Shares the single L2 memory slave port between two requesters:
  - port 0: JTAG/PULP-TAP access bridge (write32/read32 traffic);
  - port 1: on-chip test-pattern engine.
- Round-robin arbitration on a req/gnt address phase, and in-order routing of rvalid/rdata responses back to the issuing port.
- Sits between the debug/test masters and the L2 bank, inside the jtagL2test top level.

## Interface
Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, data width; byte enables are DATA_WIDTH/8.
- MAX_OUTSTANDING, 4, maximum accepted-but-unanswered transactions (power of two, ≥2).

Ports:
- clk_i  in  1  clock; single clock domain.
- rst_i  in  1  reset, synchronous, active-high.
- m_req_i  in  2  per-port request; bit i = port i.
- m_we_i  in  2  per-port write enable (1 = write).
- m_addr_i  in  2×ADDR_WIDTH  per-port address; port i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- m_be_i  in  2×DATA_WIDTH/8  per-port byte enables.
- m_wdata_i  in  2×DATA_WIDTH  per-port write data.
- m_gnt_o  out  2  per-port grant (address phase accepted).
- m_rvalid_o  out  2  per-port response valid, one cycle per transaction.
- m_rdata_o  out  DATA_WIDTH  response data, shared, qualified by m_rvalid_o.
- mem_req_o  out  1  request to L2.
- mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o  out  (1/ADDR_WIDTH/DATA_WIDTH/8/DATA_WIDTH)  muxed from the selected port.
- mem_gnt_i  in  1  L2 grant.
- mem_rvalid_i  in  1  L2 response valid; responses arrive in order, ≥1 cycle after grant.
- mem_rdata_i  in  DATA_WIDTH  L2 read data (don't-care for writes).
- err_o  out  1  sticky protocol error: response received with nothing outstanding.

## Operation
- Handshake: a transfer is accepted on a port in the cycle where m_req_i[i] & m_gnt_o[i].
  - Requesters hold req/we/addr/be/wdata stable until granted.
  - Every accepted transfer, read or write, returns exactly one m_rvalid_o pulse.
- Selection, combinational:
  - One port requesting: that port wins.
  - Both requesting: the port named by prio_q wins.
  - mem_* is muxed from the winner.
  - mem_req_o = (any m_req_i) & ~full.
  - m_gnt_o[winner] = mem_gnt_i & mem_req_o; the loser's grant is 0.
- Round-robin register prio_q:
  - Reset value 0.
  - On each accepted transfer, prio_q <= ~winner.
  - Otherwise holds.
- Owner FIFO, depth MAX_OUTSTANDING, 1-bit entries:
  - Pushes the winner id on acceptance; pops on mem_rvalid_i.
  - Occupancy counter cnt_q has width clog2(MAX_OUTSTANDING)+1; full = (cnt_q == MAX_OUTSTANDING).
  - Read/write pointers wrap modulo MAX_OUTSTANDING.
- Response routing:
  - m_rvalid_o[fifo_head] = mem_rvalid_i & ~empty.
  - m_rdata_o = mem_rdata_i, passed combinationally.
- Boundary conditions:
  - Push and pop in the same cycle: cnt_q unchanged, both pointers advance.
  - Full: mem_req_o forced 0, no grants. A pop in the full cycle re-enables requests from the next cycle.
  - mem_rvalid_i while empty: no m_rvalid_o, no pop, err_o <= 1. err_o is cleared only by rst_i.
  - rst_i asserted mid-operation: FIFO emptied, cnt_q=0, prio_q=0, err_o=0. Responses for pre-reset transactions that arrive after reset set err_o.

## Timing
- Address phase has zero added latency: mem_req_o and m_gnt_o are combinational from inputs and state.
- Response latency equals L2 latency: m_rvalid_o is in the same cycle as mem_rvalid_i.
- Reset values:
  - m_gnt_o=0 and m_rvalid_o=0 while inputs are idle.
  - mem_req_o=0 with no requests.
  - err_o=0; m_rdata_o follows mem_rdata_i.
- Throughput: one accepted transfer per cycle.
- Under contention, ports alternate every accepted transfer. Neither port waits more than one transfer of the other.
- No combinational path from mem_rvalid_i to mem_req_o. The full flag is registered-state only.

## Test plan
- Single port 0 read, 1-cycle L2:
  - Stimulus: write 0xABBAABBA at 0x0000_0000, then read it back.
  - Required: m_gnt_o=01 on each; m_rvalid_o=01 one cycle later; read m_rdata_o=0xABBAABBA; m_rvalid_o[1] never set.
- Contention:
  - Stimulus: both ports request continuously for 6 transfers, mem_gnt_i=1.
  - Required: grant sequence 0,1,0,1,0,1; responses routed to the same sequence.
- Outstanding limit:
  - Stimulus: L2 withholds rvalid; port 1 issues 5 requests.
  - Required: 4 grants, then mem_req_o=0. Releasing one rvalid allows the 5th grant on the next cycle.
- Simultaneous push/pop at full:
  - Stimulus: cnt=4, rvalid and a pending request in the same cycle.
  - Required: no grant that cycle; grant the next cycle; cnt stays at 4 after the grant.
- Spurious response:
  - Stimulus: mem_rvalid_i=1 with FIFO empty.
  - Required: m_rvalid_o=00; err_o=1 and stays 1 until rst_i.
- Reset mid-burst:
  - Stimulus: rst_i with 3 outstanding, then a new request.
  - Required: cnt=0, prio=0, err_o=0; port 0 wins the first contended request after reset.
